mfb_frame_lng_stats: RTL

Passive statistics stage directly downstream of the MFB frame length unit. Observes per-region frame lengths reported at EOF on the handshaked MFB transfer and classifies each frame as undersize, in-range or oversize. Accumulates frame, byte and error counters. A sample request freezes a consistent snapshot of all counters, with optional clear.

---
 rtl/mfb_frame_lng_stats_if.sv | 28 ++
 rtl/mfb_frame_lng_stats.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mfb_frame_lng_stats_if.sv
// MFB frame-length bus as seen by passive observers: per-region length,
// upstream-saturation flag, end-of-frame marks and the transfer handshake.
interface mfb_frame_lng_stats_if #(
  parameter int REGIONS   = 1,
  parameter int LNG_WIDTH = 16
);
  logic [REGIONS*LNG_WIDTH-1:0] RX_FRAME_LNG;
  logic [REGIONS-1:0]           RX_LNG_OVF;
  logic [REGIONS-1:0]           RX_EOF;
  logic                         RX_SRC_RDY;
  logic                         RX_DST_RDY;

  modport master (
    output RX_FRAME_LNG,
    output RX_LNG_OVF,
    output RX_EOF,
    output RX_SRC_RDY,
    output RX_DST_RDY
  );

  modport slave (
    input RX_FRAME_LNG,
    input RX_LNG_OVF,
    input RX_EOF,
    input RX_SRC_RDY,
    input RX_DST_RDY
  );
endinterface

// File: rtl/mfb_frame_lng_stats.sv
// Frame length statistics: classifies every frame ending on an accepted MFB
// word as undersize / in-range / oversize and accumulates saturating frame,
// byte and error counters. SAMPLE freezes a coherent snapshot of all counters
// (events of the SAMPLE cycle itself belong to the next period) and can
// optionally restart the live counters.
module mfb_frame_lng_stats #(
  parameter int REGIONS        = 1,
  parameter int LNG_WIDTH      = 16,
  parameter int CNT_WIDTH      = 32,
  parameter int FRAME_SIZE_MIN = 60,
  parameter int FRAME_SIZE_MAX = 1518
) (
  input  logic                  CLK,
  input  logic                  RESET,
  mfb_frame_lng_stats_if.slave  rx,
  input  logic                  SAMPLE,
  input  logic                  CLR_ON_SAMPLE,
  output logic [CNT_WIDTH-1:0]  CNT_FRAMES,
  output logic [CNT_WIDTH-1:0]  CNT_BYTES,
  output logic [CNT_WIDTH-1:0]  CNT_UNDERSIZE,
  output logic [CNT_WIDTH-1:0]  CNT_OVERSIZE,
  output logic                  CNT_VLD
);

  localparam int PC_W  = $clog2(REGIONS + 1);
  localparam int BI_W  = LNG_WIDTH + $clog2(REGIONS) + 1;
  localparam int SUM_W = ((CNT_WIDTH > BI_W) ? CNT_WIDTH : BI_W) + 1;

  localparam logic [LNG_WIDTH-1:0] LNG_MIN = LNG_WIDTH'(FRAME_SIZE_MIN);
  localparam logic [LNG_WIDTH-1:0] LNG_MAX = LNG_WIDTH'(FRAME_SIZE_MAX);

  // Saturating accumulate; an increment wider than the counter (byte sums
  // with narrow counters) is handled by summing in a wider domain.
  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] base,
    input logic [SUM_W-2:0]     inc
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + SUM_W'(inc);
    if (|sum[SUM_W-1:CNT_WIDTH]) return '1;
    return sum[CNT_WIDTH-1:0];
  endfunction

  logic [PC_W-1:0]      frm_inc_p1_d, frm_inc_p1_q;
  logic [PC_W-1:0]      und_inc_p1_d, und_inc_p1_q;
  logic [PC_W-1:0]      ovr_inc_p1_d, ovr_inc_p1_q;
  logic [BI_W-1:0]      byt_inc_p1_d, byt_inc_p1_q;
  logic                 sample_p1_q, clr_p1_q;
  logic [LNG_WIDTH-1:0] lng_r;

  logic [CNT_WIDTH-1:0] frm_live_d, frm_live_q;
  logic [CNT_WIDTH-1:0] byt_live_d, byt_live_q;
  logic [CNT_WIDTH-1:0] und_live_d, und_live_q;
  logic [CNT_WIDTH-1:0] ovr_live_d, ovr_live_q;
  logic [CNT_WIDTH-1:0] frm_snap_q, byt_snap_q, und_snap_q, ovr_snap_q;
  logic                 vld_p2_q;

  // Stage 1 combinational: per-cycle increments from every accepted EOF
  always_comb begin
    frm_inc_p1_d = '0;
    und_inc_p1_d = '0;
    ovr_inc_p1_d = '0;
    byt_inc_p1_d = '0;
    lng_r        = '0;
    for (int r = 0; r < REGIONS; r++) begin
      lng_r = rx.RX_FRAME_LNG[r*LNG_WIDTH +: LNG_WIDTH];
      if (rx.RX_LNG_OVF[r]) lng_r = '1;
      if (rx.RX_SRC_RDY && rx.RX_DST_RDY && rx.RX_EOF[r]) begin
        frm_inc_p1_d = frm_inc_p1_d + PC_W'(1);
        byt_inc_p1_d = byt_inc_p1_d + BI_W'(lng_r);
        if (rx.RX_LNG_OVF[r] || (lng_r > LNG_MAX)) ovr_inc_p1_d = ovr_inc_p1_d + PC_W'(1);
        else if (lng_r < LNG_MIN)                  und_inc_p1_d = und_inc_p1_d + PC_W'(1);
      end
    end
  end

  // Stage 1 register: increments plus the sample request travelling with them
  always_ff @(posedge CLK) begin
    if (RESET) begin
      frm_inc_p1_q <= '0;
      und_inc_p1_q <= '0;
      ovr_inc_p1_q <= '0;
      byt_inc_p1_q <= '0;
      sample_p1_q  <= 1'b0;
      clr_p1_q     <= 1'b0;
    end else begin
      frm_inc_p1_q <= frm_inc_p1_d;
      und_inc_p1_q <= und_inc_p1_d;
      ovr_inc_p1_q <= ovr_inc_p1_d;
      byt_inc_p1_q <= byt_inc_p1_d;
      sample_p1_q  <= SAMPLE;
      clr_p1_q     <= SAMPLE & CLR_ON_SAMPLE;
    end
  end

  // Stage 2 combinational: live counters accumulate, restarting from the
  // current increment when a clearing sample retires
  always_comb begin
    frm_live_d = sat_add(clr_p1_q ? '0 : frm_live_q, (SUM_W-1)'(frm_inc_p1_q));
    byt_live_d = sat_add(clr_p1_q ? '0 : byt_live_q, (SUM_W-1)'(byt_inc_p1_q));
    und_live_d = sat_add(clr_p1_q ? '0 : und_live_q, (SUM_W-1)'(und_inc_p1_q));
    ovr_live_d = sat_add(clr_p1_q ? '0 : ovr_live_q, (SUM_W-1)'(ovr_inc_p1_q));
  end

  // Stage 2 register: live counters, snapshot taken from pre-increment values
  always_ff @(posedge CLK) begin
    if (RESET) begin
      frm_live_q <= '0;
      byt_live_q <= '0;
      und_live_q <= '0;
      ovr_live_q <= '0;
      frm_snap_q <= '0;
      byt_snap_q <= '0;
      und_snap_q <= '0;
      ovr_snap_q <= '0;
      vld_p2_q   <= 1'b0;
    end else begin
      frm_live_q <= frm_live_d;
      byt_live_q <= byt_live_d;
      und_live_q <= und_live_d;
      ovr_live_q <= ovr_live_d;
      vld_p2_q   <= sample_p1_q;
      if (sample_p1_q) begin
        frm_snap_q <= frm_live_q;
        byt_snap_q <= byt_live_q;
        und_snap_q <= und_live_q;
        ovr_snap_q <= ovr_live_q;
      end
    end
  end

  assign CNT_FRAMES    = frm_snap_q;
  assign CNT_BYTES     = byt_snap_q;
  assign CNT_UNDERSIZE = und_snap_q;
  assign CNT_OVERSIZE  = ovr_snap_q;
  assign CNT_VLD       = vld_p2_q;

endmodule
